// File: rtl/lock_pkg.sv
// Shared state encoding and key constants for the keypad lock sequencer.
package lock_pkg;

    localparam int                  DIGIT_W       = 4;
    localparam logic [DIGIT_W-1:0]  KEY_NONE      = 4'd0;
    localparam int                  DEF_ENTER_KEY = 12;
    localparam int                  DEF_CLEAR_KEY = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_OPEN,
        ST_LOCKOUT,
        ST_PROG
    } lock_state_e;

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the timed states; o_expire marks the cycle the count steps 1 -> 0.
// A load on that same cycle wins; the controller gives key events priority over expiry anyway.
module lock_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_value,
    output logic               o_expire
);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - TIMER_W'(1);
        end
    end

    assign o_expire = (r_count == TIMER_W'(1));

endmodule

// File: rtl/lock_sequencer.sv
// Keypad lock controller: press detection, code entry and compare, unlock hold, failure lockout.
// Outputs are registered one cycle after the key edge; LOCK_SEQ_REPROG_EN adds code reprogramming from OPEN.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int CODE_LEN       = 4,
    parameter int MAX_FAILS      = 3,
    parameter int ENTER_KEY      = DEF_ENTER_KEY,
    parameter int CLEAR_KEY      = DEF_CLEAR_KEY,
    parameter int OPEN_CYCLES    = 100,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int ENTRY_TIMEOUT  = 500,
    parameter int TIMER_W        = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DIGIT_W-1:0]          key,
    input  logic [DIGIT_W*CODE_LEN-1:0] code,
    output logic                        unlock,
    output logic                        locked_out,
    output logic                        entry_active,
    output logic                        fail_pulse,
    output logic [3:0]                  digit_count
);

    localparam int FAIL_W = $clog2(MAX_FAILS + 1);

    lock_state_e                 r_state, w_next;
    logic [DIGIT_W-1:0]          r_prev_key;
    logic [DIGIT_W*CODE_LEN-1:0] r_buf, w_code;
    logic [3:0]                  r_count;
    logic                        r_overflow, r_fail_pulse;
    logic [FAIL_W-1:0]           r_fail_cnt;
    logic                        w_event, w_enter, w_clear_key, w_digit, w_full, w_match, w_expire;
    logic                        w_tmr_load;
    logic [TIMER_W-1:0]          w_tmr_value;
    logic                        w_store, w_clear, w_fail, w_fail_rst;

    assign w_event     = (key != KEY_NONE) && (key != r_prev_key);
    assign w_enter     = w_event && (key == DIGIT_W'(ENTER_KEY));
    assign w_clear_key = w_event && (key == DIGIT_W'(CLEAR_KEY));
    assign w_digit     = w_event && !w_enter && !w_clear_key;
    assign w_full      = (r_count == 4'(CODE_LEN)) && !r_overflow;
    assign w_match     = w_full && (r_buf == w_code);

`ifdef LOCK_SEQ_REPROG_EN
    logic [DIGIT_W*CODE_LEN-1:0] r_code;
    logic                        w_prog_wr;

    // The port only seeds the stored code while reset is held.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_code <= code;
        end else if (w_prog_wr) begin
            r_code <= r_buf;
        end
    end
    assign w_code = r_code;
`else
    assign w_code = code;
`endif

    lock_timer #(.TIMER_W(TIMER_W)) u_timer (
        .i_clock  (clock),
        .i_reset  (reset),
        .i_load   (w_tmr_load),
        .i_value  (w_tmr_value),
        .o_expire (w_expire)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Key events are tested before expiry so a press on the last cycle still counts.
    always_comb begin
        w_next      = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_value = '0;
        w_store     = 1'b0;
        w_clear     = 1'b0;
        w_fail      = 1'b0;
        w_fail_rst  = 1'b0;
`ifdef LOCK_SEQ_REPROG_EN
        w_prog_wr   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_digit) begin
                    w_next      = ST_ENTRY;
                    w_store     = 1'b1;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = TIMER_W'(ENTRY_TIMEOUT);
                end
            end
            ST_ENTRY: begin
                if (w_clear_key) begin
                    w_next     = ST_IDLE;
                    w_clear    = 1'b1;
                    w_tmr_load = 1'b1;
                end else if (w_enter) begin
                    w_clear    = 1'b1;
                    w_tmr_load = 1'b1;
                    if (w_match) begin
                        w_next      = ST_OPEN;
                        w_fail_rst  = 1'b1;
                        w_tmr_value = TIMER_W'(OPEN_CYCLES);
                    end else begin
                        w_fail = 1'b1;
                        if (r_fail_cnt == FAIL_W'(MAX_FAILS - 1)) begin
                            w_next      = ST_LOCKOUT;
                            w_tmr_value = TIMER_W'(LOCKOUT_CYCLES);
                        end else begin
                            w_next = ST_IDLE;
                        end
                    end
                end else if (w_digit) begin
                    w_store     = 1'b1;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = TIMER_W'(ENTRY_TIMEOUT);
                end else if (w_expire) begin
                    w_next  = ST_IDLE;
                    w_clear = 1'b1;
                end
            end
            ST_OPEN: begin
                if (w_enter || w_expire) begin
                    w_next     = ST_IDLE;
                    w_tmr_load = 1'b1;
                end
`ifdef LOCK_SEQ_REPROG_EN
                else if (w_clear_key) begin
                    w_next      = ST_PROG;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = TIMER_W'(ENTRY_TIMEOUT);
                end
`endif
            end
            ST_LOCKOUT: begin
                if (w_expire) begin
                    w_next     = ST_IDLE;
                    w_fail_rst = 1'b1;
                end
            end
`ifdef LOCK_SEQ_REPROG_EN
            ST_PROG: begin
                if (w_digit) begin
                    w_store     = 1'b1;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = TIMER_W'(ENTRY_TIMEOUT);
                end else if (w_clear_key || w_enter || w_expire) begin
                    w_next     = ST_IDLE;
                    w_clear    = 1'b1;
                    w_tmr_load = 1'b1;
                    w_prog_wr  = w_enter && w_full;
                end
            end
`endif
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_prev_key   <= KEY_NONE;
            r_buf        <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_fail_cnt   <= '0;
            r_fail_pulse <= 1'b0;
        end else begin
            r_prev_key   <= key;
            r_fail_pulse <= w_fail;
            if (w_clear) begin
                r_buf      <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else if (w_store) begin
                if (r_count < 4'(CODE_LEN)) begin
                    for (int i = 0; i < CODE_LEN; i++) begin
                        if (r_count == 4'(i)) begin
                            r_buf[DIGIT_W*i +: DIGIT_W] <= key;
                        end
                    end
                    r_count <= r_count + 4'd1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end
            if (w_fail_rst) begin
                r_fail_cnt <= '0;
            end else if (w_fail) begin
                r_fail_cnt <= r_fail_cnt + FAIL_W'(1);
            end
        end
    end

    always_comb begin
        unlock       = (r_state == ST_OPEN);
        locked_out   = (r_state == ST_LOCKOUT);
        entry_active = (r_state == ST_ENTRY) || (r_state == ST_PROG);
        fail_pulse   = r_fail_pulse;
        digit_count  = r_count;
    end

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: directed test-plan scenarios plus randomized key traffic against a behavioural model.
module tb_lock_sequencer;

    localparam int          CL    = 4;
    localparam int          MAXF  = 3;
    localparam int          ENT   = 12;
    localparam int          CLR   = 10;
    localparam int          OPENC = 100;
    localparam int          LOCKC = 1000;
    localparam int          TMO   = 500;
    localparam logic [15:0] CODE  = 16'h1645;
    localparam logic [15:0] WRONG = 16'h2645;

    localparam int M_IDLE = 0, M_ENTRY = 1, M_OPEN = 2, M_LOCK = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  key   = 4'd0;
    logic [15:0] code  = CODE;
    logic        unlock, locked_out, entry_active, fail_pulse;
    logic [3:0]  digit_count;

    always #5 clock = ~clock;

    lock_sequencer #(
        .CODE_LEN(CL), .MAX_FAILS(MAXF), .ENTER_KEY(ENT), .CLEAR_KEY(CLR),
        .OPEN_CYCLES(OPENC), .LOCKOUT_CYCLES(LOCKC), .ENTRY_TIMEOUT(TMO), .TIMER_W(16)
    ) dut (
        .clock(clock), .reset(reset), .key(key), .code(code),
        .unlock(unlock), .locked_out(locked_out), .entry_active(entry_active),
        .fail_pulse(fail_pulse), .digit_count(digit_count)
    );

    // Model: entry kept as a queue of digits, timed states as absolute deadlines.
    int cyc = 0, m_mode = M_IDLE, m_fails = 0, m_deadline = 0, m_prev = 0, m_k = 0;
    int m_digits[$];
    bit m_ovf = 1'b0, m_fpulse = 1'b0, m_ev = 1'b0;

    function automatic bit code_ok();
        if (m_digits.size() != CL || m_ovf) return 1'b0;
        for (int i = 0; i < CL; i++)
            if (m_digits[i] != int'((CODE >> (4 * i)) & 16'hF)) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clock) begin
        cyc++;
        m_k = int'(key);
        if (!reset) begin
            m_mode = M_IDLE; m_digits.delete(); m_ovf = 1'b0;
            m_fails = 0; m_prev = 0; m_fpulse = 1'b0;
        end else begin
            m_ev = (m_k != 0) && (m_k != m_prev);
            m_prev = m_k;
            m_fpulse = 1'b0;
            case (m_mode)
                M_IDLE: if (m_ev && m_k != ENT && m_k != CLR) begin
                    m_digits.delete(); m_digits.push_back(m_k);
                    m_mode = M_ENTRY; m_deadline = cyc + TMO;
                end
                M_ENTRY: if (m_ev) begin
                    if (m_k == CLR) begin
                        m_mode = M_IDLE;
                    end else if (m_k == ENT) begin
                        if (code_ok()) begin
                            m_fails = 0; m_mode = M_OPEN; m_deadline = cyc + OPENC;
                        end else begin
                            m_fpulse = 1'b1; m_fails++;
                            if (m_fails >= MAXF) begin
                                m_mode = M_LOCK; m_deadline = cyc + LOCKC;
                            end else begin
                                m_mode = M_IDLE;
                            end
                        end
                    end else begin
                        if (m_digits.size() < CL) m_digits.push_back(m_k);
                        else m_ovf = 1'b1;
                        m_deadline = cyc + TMO;
                    end
                    if (m_mode != M_ENTRY) begin m_digits.delete(); m_ovf = 1'b0; end
                end else if (cyc == m_deadline) begin
                    m_digits.delete(); m_ovf = 1'b0; m_mode = M_IDLE;
                end
                M_OPEN: if ((m_ev && m_k == ENT) || cyc == m_deadline) m_mode = M_IDLE;
                M_LOCK: if (cyc == m_deadline) begin m_fails = 0; m_mode = M_IDLE; end
                default: m_mode = M_IDLE;
            endcase
        end
    end

    int checks = 0, errors = 0;
    int n_unlock = 0, n_lock = 0, n_fp = 0, first_unlock = 0;

    function automatic int outs();
        return int'({unlock, locked_out, entry_active, fail_pulse, digit_count});
    endfunction

    // Every clock advance of the bench goes through here, so the model is compared on every cycle.
    task automatic tick();
        logic [7:0] act, exp;
        @(negedge clock);
        act = {unlock, locked_out, entry_active, fail_pulse, digit_count};
        exp = {m_mode == M_OPEN, m_mode == M_LOCK, m_mode == M_ENTRY, m_fpulse, 4'(m_digits.size())};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL model_cycle cyc=%0d got=%b want=%b", cyc, act, exp);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic run_key(input int k, input int hold, input int window);
        key = 4'(k);
        for (int i = 0; i < window; i++) begin
            tick();
            if (i == 0) first_unlock = int'(unlock);
            n_unlock += int'(unlock);
            n_lock   += int'(locked_out);
            n_fp     += int'(fail_pulse);
            if (i == hold - 1) key = 4'd0;
        end
    endtask

    task automatic clr_cnt();
        n_unlock = 0; n_lock = 0; n_fp = 0;
    endtask

    task automatic digits(input logic [15:0] c);
        for (int i = 0; i < CL; i++) run_key(int'((c >> (4 * i)) & 16'hF), 8, 9);
    endtask

    task automatic wrong_attempt();
        digits(WRONG);
        run_key(ENT, 8, 10);
    endtask

    initial begin
        int r, h, g, d;
        repeat (3) tick();
        chk("reset_outputs", outs(), 0);
        reset = 1'b1;
        repeat (2) tick();

        // Correct code opens for exactly OPEN_CYCLES.
        digits(CODE);
        clr_cnt();
        run_key(ENT, 8, 130);
        chk("open_first_cycle", first_unlock, 1);
        chk("open_length", n_unlock, OPENC);

        // Three failures, lockout ignores a correct code, then lockout expires.
        clr_cnt();
        repeat (3) wrong_attempt();
        digits(CODE);
        run_key(ENT, 8, 9);
        run_key(0, 1, 1000);
        chk("fail_pulses", n_fp, 3);
        chk("lockout_length", n_lock, LOCKC);
        chk("unlock_in_lockout", n_unlock, 0);
        digits(CODE);
        run_key(ENT, 8, 20);
        chk("open_after_lockout", first_unlock, 1);
        clr_cnt();
        run_key(ENT, 2, 3);
        chk("enter_relocks", n_unlock, 0);

        // Held key is one event; release re-arms it.
        run_key(5, 40, 41);
        chk("held_key_count", int'(digit_count), 1);
        run_key(5, 8, 9);
        chk("rearm_count", int'(digit_count), 2);
        run_key(CLR, 8, 9);
        chk("clear_count", int'(digit_count), 0);
        chk("clear_idle", int'(entry_active), 0);

        // Fifth digit overflows and the entry fails.
        clr_cnt();
        digits(CODE);
        run_key(3, 8, 9);
        run_key(ENT, 8, 10);
        chk("overflow_fail", n_fp, 1);
        chk("overflow_no_unlock", n_unlock, 0);
        clr_cnt();
        run_key(5, 8, 9);
        run_key(4, 8, 9);
        run_key(CLR, 8, 9);
        chk("clear_no_fail", n_fp, 0);
        chk("clear_count2", int'(digit_count), 0);

        // Entry timeout boundary, failure count kept across it.
        run_key(5, 8, 9);
        run_key(4, 8, 9);
        run_key(0, 1, 491);
        chk("timeout_still_active", int'(entry_active), 1);
        run_key(0, 1, 1);
        chk("timeout_expired", int'(entry_active), 0);
        chk("timeout_count", int'(digit_count), 0);
        wrong_attempt();
        chk("second_fail_no_lock", int'(locked_out), 0);
        wrong_attempt();
        chk("third_fail_locks", int'(locked_out), 1);

        // Reset during lockout clears the failure count.
        reset = 1'b0;
        tick();
        chk("reset_in_lockout", outs(), 0);
        reset = 1'b1;
        tick();
        wrong_attempt();
        wrong_attempt();
        chk("post_reset_two_fails", int'(locked_out), 0);
        wrong_attempt();
        chk("post_reset_third_fail", int'(locked_out), 1);
        run_key(0, 1, 1000);

        // Reset 50 cycles into OPEN.
        digits(CODE);
        clr_cnt();
        run_key(ENT, 8, 50);
        chk("open_before_reset", n_unlock, 50);
        reset = 1'b0;
        tick();
        chk("reset_in_open", outs(), 0);
        reset = 1'b1;
        tick();

        // Randomized traffic checked cycle by cycle against the model.
        for (int t = 0; t < 1200; t++) begin
            r = int'($urandom_range(0, 99));
            if (r < 35) begin
                for (int i = 0; i < CL; i++) begin
                    d = int'((CODE >> (4 * i)) & 16'hF);
                    if ($urandom_range(0, 7) == 0) d = int'($urandom_range(1, 15));
                    h = int'($urandom_range(1, 4));
                    g = int'($urandom_range(0, 2));
                    run_key(d, h, h + g);
                end
                h = int'($urandom_range(1, 4));
                run_key(ENT, h, h + int'($urandom_range(1, 3)));
            end else if (r < 97) begin
                h = int'($urandom_range(1, 4));
                g = int'($urandom_range(0, 2));
                run_key(int'($urandom_range(1, 15)), h, h + g);
            end else if (r < 98) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end else begin
                run_key(0, 1, int'($urandom_range(450, 560)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
